// File: rtl/dmem_pkg.sv
// Shared types for the LSU data memory.
//   mem_size_t   : access size encoding carried on req_size
//   dmem_state_t : request-sequencing FSM states
//   misaligned() : alignment fault test for a size / byte-lane pair
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_RESPOND = 2'b10
  } dmem_state_t;

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] lane);
    case (size)
      SIZE_HALF: misaligned = lane[0];
      SIZE_WORD: misaligned = (lane != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational lane steering for the data memory.
//   size, lane, is_unsigned : access size, byte lane (address[1:0]), load extension mode
//   store_data              : right-aligned store data
//   old_word                : current contents of the addressed word
//   merged_word             : old_word with the store lanes replaced
//   load_data               : addressed byte/half/word, sign- or zero-extended
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] old_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val    = old_word[{lane, 3'b000} +: 8];
    half_val    = old_word[{lane[1], 4'b0000} +: 16];
    merged_word = old_word;
    load_data   = '0;
    case (size)
      SIZE_BYTE: begin
        merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
        load_data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
      end
      SIZE_HALF: begin
        merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
        load_data = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
      end
      SIZE_WORD: begin
        merged_word = store_data;
        load_data   = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_data_memory.sv
// Single-port data memory behind a valid/ready load-store request interface.
// One request in flight: IDLE -> (WAIT x WAIT_CYCLES) -> RESPOND -> IDLE.
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   req_*              : request; accepted when req_valid && req_ready
//   resp_valid         : one-cycle response strobe
//   resp_read_data     : extended load data (0 for stores, errors, idle)
//   resp_error         : alignment / reserved-size / out-of-range fault
// Optional build macro DMEM_PRELOAD_EN: words 0,1,2 = 100,200,300, others 0.
module lsu_data_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);
  import dmem_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        accept, enter_resp;

  logic        lat_write, lat_unsigned;
  mem_size_t   lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic        cur_write, cur_unsigned, cur_err, in_range;
  mem_size_t   cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] mem_idx;
  logic [31:0] old_word, merged_word, load_data;

`ifdef DMEM_PRELOAD_EN
  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[AW'(i)] = '0;
    mem[AW'(0)] = 32'd100;
    mem[AW'(1)] = 32'd200;
    mem[AW'(2)] = 32'd300;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    accept        = 1'b0;
    enter_resp    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESPOND;
            enter_resp = 1'b1;
          end else begin
            state_next    = ST_WAIT;
            wait_cnt_next = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next    = ST_RESPOND;
          enter_resp    = 1'b1;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESPOND);

  // With zero wait states the RESPOND-entry edge is also the accept edge, so
  // the access is served straight from the request inputs in IDLE.
  assign cur_write    = (state == ST_IDLE) ? req_write                  : lat_write;
  assign cur_size     = (state == ST_IDLE) ? mem_size_t'(req_size)      : lat_size;
  assign cur_unsigned = (state == ST_IDLE) ? req_unsigned               : lat_unsigned;
  assign cur_addr     = (state == ST_IDLE) ? req_address                : lat_addr;
  assign cur_wdata    = (state == ST_IDLE) ? req_write_data             : lat_wdata;

  assign in_range = ({2'b00, cur_addr[31:2]} < DEPTH_WORDS);
  assign cur_err  = !in_range || (cur_size == SIZE_RSVD) || misaligned(cur_size, cur_addr[1:0]);
  assign mem_idx  = cur_addr[AW+1:2];
  assign old_word = mem[mem_idx];

  dmem_byte_lane u_lane (
    .size        (cur_size),
    .lane        (cur_addr[1:0]),
    .is_unsigned (cur_unsigned),
    .store_data  (cur_wdata),
    .old_word    (old_word),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write      <= 1'b0;
      lat_unsigned   <= 1'b0;
      lat_size       <= SIZE_BYTE;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      resp_read_data <= '0;
      resp_error     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_size     <= mem_size_t'(req_size);
        lat_addr     <= req_address;
        lat_wdata    <= req_write_data;
      end
      resp_read_data <= (enter_resp && !cur_write && !cur_err) ? load_data : '0;
      resp_error     <= enter_resp && cur_err;
    end
  end

  // Memory contents survive reset; a reset edge suppresses the commit.
  always_ff @(posedge clock) begin
    if (enter_resp && !reset && cur_write && !cur_err)
      mem[mem_idx] <= merged_word;
  end

endmodule

// File: doc/lsu_data_memory.md
LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 4..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra access wait states; 0..15.
REQ-003 SHALL have port clock, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_address, input, 32, byte address.
REQ-011 SHALL have port req_write_data, input, 32, store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1, one-cycle response strobe.
REQ-013 SHALL have port resp_read_data, output, 32, extended load result; 0 for stores and errors.
REQ-014 SHALL have port resp_error, output, 1, access faulted; valid only with resp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESPOND; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on an edge with IDLE and req_valid = 1, latching all req_* fields; go to WAIT if WAIT_CYCLES > 0, else RESPOND.
REQ-017 SHALL stay in WAIT for exactly WAIT_CYCLES cycles using a down-counter, then go to RESPOND.
REQ-018 SHALL commit stores and capture load data on the edge entering RESPOND.
REQ-019 SHALL assert resp_valid for exactly the one RESPOND cycle, then return to IDLE; no response back-pressure.
REQ-020 SHALL give latency: accept at edge N, resp_valid high in cycle N+WAIT_CYCLES+1; throughput one request per WAIT_CYCLES+2 cycles.
REQ-021 SHALL use word index req_address[31:2] and byte lane req_address[1:0].
REQ-022 SHALL, for byte store, write only lane address[1:0] with write_data[7:0]; half store writes lanes {a[1],0} and {a[1],1} with write_data[15:0]; word store writes all lanes.
REQ-023 SHALL, for loads, extract the addressed byte or half and sign- or zero-extend per req_unsigned; word loads ignore req_unsigned.
REQ-024 SHALL flag resp_error = 1 for: half with address[0] = 1; word with address[1:0] != 0; req_size = 11; word index >= DEPTH_WORDS.
REQ-025 SHALL, on error, leave memory unmodified and drive resp_read_data = 0.
REQ-026 SHALL ignore req_valid and all req_* inputs outside IDLE.
REQ-027 SHALL drive resp_read_data = 0 and resp_error = 0 whenever resp_valid = 0.

Reset
REQ-028 SHALL, on reset assertion at any time, force IDLE, counter 0, resp_valid 0, resp_read_data 0, resp_error 0; req_ready = 1 after release.
REQ-029 SHALL abort an in-flight request on reset without committing its store, if the RESPOND-entry edge has not occurred.
REQ-030 SHALL NOT clear memory contents on reset.

Configuration
REQ-031 SHALL, with DMEM_PRELOAD_EN defined, initialise words 0, 1, 2 to 100, 200, 300 at time zero, other words 0.
REQ-032 SHALL, without DMEM_PRELOAD_EN, leave memory contents uninitialised; no initial block is present.

Structure
REQ-033 SHALL place in package dmem_pkg: mem_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD), the FSM state enum, and the size encodings.
REQ-034 SHALL put lane merge for stores and extract/extend for loads in combinational sub-module dmem_byte_lane.

Verification
REQ-035 SHALL verify with WAIT_CYCLES = 1 and DMEM_PRELOAD_EN: load word addr 0x4 -> resp_valid in cycle N+2, data 200, error 0.
REQ-036 SHALL verify: store byte 0xFF at 0x9 over preloaded 300 (0x12C); load word 0x8 -> 0x0000FF2C; load byte 0x9 signed -> 0xFFFFFFFF; unsigned -> 0x000000FF.
REQ-037 SHALL verify: store half 0x8001 at 0x12, load half 0x12 signed -> 0xFFFF8001, unsigned -> 0x00008001.
REQ-038 SHALL verify: word load 0x6, half store 0x3, size 11, address 4*DEPTH_WORDS -> resp_error 1, data 0, memory unchanged.
REQ-039 SHALL verify: reset asserted in WAIT of a store 0xDEADBEEF to 0x10 -> no write (word 4 reads old value), resp_valid never pulses, req_ready 1 after release.
REQ-040 SHALL verify: req_valid held high back-to-back with WAIT_CYCLES = 0 -> requests accepted every 2 cycles, req_ready low in RESPOND.
